mips32_result_dumper: RTL and testbench
=======================================

# mips32_result_dumper

Post-halt result extraction engine for the MIPS32 pipelined core. Once the core halts, it reads the length word and the array region out of the core's data memory through a dedicated read port. It streams each element out over a valid/ready interface and reports whether the array is non-decreasing under signed comparison. It replaces hand-written `$display` checks of sorted memory with a reusable hardware stage downstream of the core.

## Interface
Parameters:
- AW, 10, memory word-address width
- DW, 32, data word width
- N_ADDR, 99, word address holding element count N
- BASE_ADDR, 100, word address of element 0
- MAX_N, 256, largest accepted N

Ports (clk1 is the single clock for this block; rst is synchronous, active-high):
- clk1  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  begin a dump; sampled only in IDLE or DONE
- rd_en  out  1  memory read request
- rd_addr  out  AW  memory read address
- rd_data  in  DW  read data, valid exactly one cycle after rd_en
- out_valid  out  1  element beat valid
- out_ready  in  1  consumer accepts beat
- out_data  out  DW  element value
- out_index  out  AW  element index j (0-based)
- out_last  out  1  beat is element N-1
- busy  out  1  high in every state except IDLE/DONE
- done  out  1  high in DONE
- sorted  out  1  result flag, meaningful when done=1
- err_len  out  1  N rejected (N > MAX_N as unsigned)

## Operation
- Reset values: all outputs 0; state IDLE; internal n, idx, prev cleared.
- States:
  - IDLE
  - REQ_N
  - LAT_N
  - REQ_EL
  - LAT_EL
  - OUT
  - DONE
- IDLE/DONE: on start=1, go to REQ_N. Entering REQ_N clears done, sorted and err_len.
- REQ_N: rd_en=1, rd_addr=N_ADDR; go to LAT_N.
- LAT_N: capture n=rd_data.
  - n==0: go to DONE with sorted=1.
  - n>MAX_N (unsigned, so bit 31 set also rejects): go to DONE with err_len=1, sorted=0.
  - Otherwise: idx=0, sorted_acc=1, go to REQ_EL.
- REQ_EL: rd_en=1, rd_addr=(BASE_ADDR+idx) truncated to AW bits; go to LAT_EL.
- LAT_EL: register rd_data into out_data, idx into out_index, and (idx==n-1) into out_last; go to OUT.
- OUT: out_valid=1. On out_valid&&out_ready:
  - If idx>0 and $signed(out_data) < $signed(prev), clear sorted_acc.
  - Set prev=out_data.
  - If out_last: go to DONE with sorted=sorted_acc.
  - Else: idx=idx+1, go to REQ_EL.
- rd_en is 0 in all states other than REQ_N and REQ_EL.
- Equal adjacent values count as sorted.
- out_data, out_index and out_last hold stable while out_valid=1 and out_ready=0. out_valid never drops without a handshake, except on rst.
- start while busy is ignored.
- start in DONE restarts the dump; done drops on the next cycle.
- rst in any state, including mid-beat with out_valid=1, returns to IDLE on the next edge. All outputs go to 0 and no further rd_en is issued.
- idx is AW bits wide. Because MAX_N ≤ 2^AW, idx never wraps.

## Timing
- Read latency is fixed at 1 cycle; the block never issues back-to-back reads.
- start-to-first-beat: start sampled at edge 0; REQ_N cycle 1, LAT_N cycle 2, REQ_EL cycle 3, LAT_EL cycle 4, out_valid high in cycle 5.
- Steady state with out_ready=1: one beat every 3 cycles (REQ_EL, LAT_EL, OUT).
- Total from start to done=1 with out_ready=1: 2+3N cycles after the start edge, plus 1 for the DONE register.
- N==0 or rejected N: done=1 three cycles after start (IDLE→REQ_N→LAT_N→DONE).
- sorted and err_len change only on entry to DONE or on the start-triggered clear.

## Test plan
- Memory N=4, [10,20,25,50], out_ready=1 → four beats with data 10,20,25,50 and indices 0..3; out_last only on index 3; done=1, sorted=1, err_len=0; rd_addr sequence 99,100,101,102,103.
- Memory N=4, [10,25,50,20] → same beat count; done=1, sorted=0.
- Backpressure: N=2, [7,3], out_ready low for 5 cycles during beat 0 → out_valid stays 1, out_data=7 and out_index=0 stable all 5 cycles, no rd_en issued; after release, beat 1=3 arrives; sorted=0.
- Signed compare: N=3, [0xFFFFFFFF,0,5] → sorted=1 (since -1<0<5).
- Length edge cases:
  - N=0 → no beats, done=1 three cycles after start, sorted=1.
  - N=300 → no beats, done=1, err_len=1, sorted=0.
  - N=256 → 256 beats, last rd_addr=355.
- Reset mid-operation: rst asserted while out_valid=1 on beat 2 of 4 → next cycle all outputs 0 and state IDLE; a subsequent start performs a complete fresh dump from index 0.

Source files
------------

// File: rtl/mips32_result_dumper.sv
// Purpose: after the core halts, reads N and N array words from data memory and streams them out with a signed non-decreasing check.
// Latency: first beat 5 cycles after start; then one beat per 3 cycles; done 2+3N+1 cycles after start (3 for N==0 or rejected N).
// Backpressure: out_ready low holds the OUT beat stable; no memory reads are issued while a beat is pending.
module mips32_result_dumper #(
    parameter int AW        = 10,
    parameter int DW        = 32,
    parameter int N_ADDR    = 99,
    parameter int BASE_ADDR = 100,
    parameter int MAX_N     = 256
) (
    input  logic          clk1,
    input  logic          rst,
    input  logic          start,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW-1:0] out_index,
    output logic          out_last,
    output logic          busy,
    output logic          done,
    output logic          sorted,
    output logic          err_len
);

    typedef enum logic [2:0] {
        IDLE, REQ_N, LAT_N, REQ_EL, LAT_EL, OUT, DONE
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] n_q, n_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [DW-1:0] prev_q, prev_d;
    logic          acc_q, acc_d;
    logic [DW-1:0] data_q, data_d;
    logic [AW-1:0] index_q, index_d;
    logic          last_q, last_d;
    logic          sorted_q, sorted_d;
    logic          err_q, err_d;
    logic          acc_upd;

    // State and datapath registers; reset returns everything to zero and IDLE.
    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q  <= IDLE;
            n_q      <= '0;
            idx_q    <= '0;
            prev_q   <= '0;
            acc_q    <= 1'b0;
            data_q   <= '0;
            index_q  <= '0;
            last_q   <= 1'b0;
            sorted_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            idx_q    <= idx_d;
            prev_q   <= prev_d;
            acc_q    <= acc_d;
            data_q   <= data_d;
            index_q  <= index_d;
            last_q   <= last_d;
            sorted_q <= sorted_d;
            err_q    <= err_d;
        end
    end

    // Next-state, memory request and beat handshake logic.
    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        idx_d     = idx_q;
        prev_d    = prev_q;
        acc_d     = acc_q;
        data_d    = data_q;
        index_d   = index_q;
        last_d    = last_q;
        sorted_d  = sorted_q;
        err_d     = err_q;
        acc_upd   = acc_q;
        rd_en     = 1'b0;
        rd_addr   = '0;
        out_valid = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = REQ_N;
                    sorted_d = 1'b0;
                    err_d    = 1'b0;
                end
            end
            REQ_N: begin
                rd_en   = 1'b1;
                rd_addr = AW'(N_ADDR);
                state_d = LAT_N;
            end
            LAT_N: begin
                n_d = rd_data;
                if (rd_data == '0) begin
                    state_d  = DONE;
                    sorted_d = 1'b1;
                end else if (rd_data > DW'(MAX_N)) begin
                    // Unsigned compare: negative-looking lengths are rejected too.
                    state_d  = DONE;
                    err_d    = 1'b1;
                    sorted_d = 1'b0;
                end else begin
                    idx_d   = '0;
                    acc_d   = 1'b1;
                    state_d = REQ_EL;
                end
            end
            REQ_EL: begin
                rd_en   = 1'b1;
                rd_addr = AW'(BASE_ADDR) + idx_q;
                state_d = LAT_EL;
            end
            LAT_EL: begin
                data_d  = rd_data;
                index_d = idx_q;
                last_d  = (DW'(idx_q) == n_q - DW'(1));
                state_d = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if ((idx_q != '0) && ($signed(data_q) < $signed(prev_q)))
                        acc_upd = 1'b0;
                    acc_d  = acc_upd;
                    prev_d = data_q;
                    if (last_q) begin
                        state_d  = DONE;
                        sorted_d = acc_upd;
                    end else begin
                        idx_d   = idx_q + AW'(1);
                        state_d = REQ_EL;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_data  = data_q;
    assign out_index = index_q;
    assign out_last  = last_q;
    assign busy      = (state_q != IDLE) && (state_q != DONE);
    assign done      = (state_q == DONE);
    assign sorted    = sorted_q;
    assign err_len   = err_q;

endmodule

// File: tb/tb_mips32_result_dumper.sv
// Bench for mips32_result_dumper: memory model, beat monitor, table vectors,
// randomized dumps against a reference model, reset-mid-beat sequence.
module tb_mips32_result_dumper;

    logic        clk1 = 1'b0;
    logic        rst, start, out_ready;
    logic        rd_en, out_valid, out_last, busy, done, sorted, err_len;
    logic [9:0]  rd_addr, out_index;
    logic [31:0] rd_data, out_data;

    mips32_result_dumper dut (
        .clk1(clk1), .rst(rst), .start(start),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_index(out_index), .out_last(out_last), .busy(busy),
        .done(done), .sorted(sorted), .err_len(err_len)
    );

    always #5 clk1 = ~clk1;

    logic [31:0] mem [1024];

    always @(posedge clk1) if (rd_en) rd_data <= mem[rd_addr];

    int compared = 0;
    int mismatched = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Observed traffic
    logic [31:0] got_data[$];
    int          got_idx[$];
    logic        got_last[$];
    int          addr_log[$];

    logic        hold = 1'b0;
    logic [31:0] hd;
    logic [9:0]  hi;
    logic        hl;

    always @(negedge clk1) begin
        if (rst) begin
            hold = 1'b0;
        end else begin
            if (rd_en) addr_log.push_back(int'(rd_addr));
            if (hold) begin
                chk("hold_valid", {31'b0, out_valid}, 1);
                chk("hold_data", out_data, hd);
                chk("hold_index", {22'b0, out_index}, {22'b0, hi});
                chk("hold_last", {31'b0, out_last}, {31'b0, hl});
            end
            if (out_valid) begin
                chk("no_read_during_beat", {31'b0, rd_en}, 0);
                if (out_ready) begin
                    got_data.push_back(out_data);
                    got_idx.push_back(int'(out_index));
                    got_last.push_back(out_last);
                end
                hold = !out_ready;
                hd = out_data; hi = out_index; hl = out_last;
            end else begin
                hold = 1'b0;
            end
        end
    end

    task automatic clear_logs();
        got_data.delete(); got_idx.delete(); got_last.delete(); addr_log.delete();
    endtask

    // mode 0: ready always 1; mode 1: random ready; mode 2: ready low 5 cycles on beat 0
    task automatic do_dump(input int mode, output int cyc);
        int lowc = 0;
        clear_logs();
        @(negedge clk1);
        start = 1'b1;
        out_ready = 1'b1;
        @(posedge clk1); #1;
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 4000) begin
            if (mode == 1) out_ready = 1'($urandom_range(0, 1));
            else if (mode == 2 && out_valid && out_index == 0 && lowc < 5) begin
                out_ready = 1'b0; lowc++;
            end else out_ready = 1'b1;
            @(posedge clk1); #1;
            cyc++;
        end
        out_ready = 1'b1;
        if (!done) chk("dump_timeout", 0, 1);
    endtask

    // Reference: derive the whole expected dump from memory contents.
    task automatic check_dump(input string tag, input int exp_cyc, input int cyc);
        logic [31:0] n = mem[99];
        logic [31:0] q[$];
        int          exp_addr[$];
        logic        s = 1'b1, e = 1'b0;
        exp_addr.push_back(99);
        if (n > 256) begin
            e = 1'b1; s = 1'b0;
        end else begin
            for (int j = 0; j < int'(n); j++) begin
                q.push_back(mem[100 + j]);
                exp_addr.push_back(100 + j);
                if (j > 0 && $signed(mem[100 + j]) < $signed(mem[99 + j])) s = 1'b0;
            end
        end
        chk({tag, "_beats"}, got_data.size(), q.size());
        for (int j = 0; j < q.size() && j < got_data.size(); j++) begin
            chk({tag, "_data"}, got_data[j], q[j]);
            chk({tag, "_index"}, got_idx[j], j);
            chk({tag, "_last"}, {31'b0, got_last[j]}, (j == q.size() - 1) ? 1 : 0);
        end
        chk({tag, "_nreads"}, addr_log.size(), exp_addr.size());
        for (int j = 0; j < exp_addr.size() && j < addr_log.size(); j++)
            chk({tag, "_rd_addr"}, addr_log[j], exp_addr[j]);
        chk({tag, "_done"}, {31'b0, done}, 1);
        chk({tag, "_busy"}, {31'b0, busy}, 0);
        chk({tag, "_sorted"}, {31'b0, sorted}, {31'b0, s});
        chk({tag, "_err_len"}, {31'b0, err_len}, {31'b0, e});
        if (exp_cyc > 0) chk({tag, "_cycles"}, cyc, exp_cyc);
    endtask

    typedef struct {
        logic [31:0]       n;
        logic [3:0][31:0]  e;
        int                mode;
        logic              exp_sorted;
        logic              exp_err;
        int                exp_cyc;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic [31:0] n, input logic [31:0] e0, e1, e2, e3,
                           input int mode, input logic s, input logic er, input int cy);
        vec_t v;
        v.n = n; v.e[0] = e0; v.e[1] = e1; v.e[2] = e2; v.e[3] = e3;
        v.mode = mode; v.exp_sorted = s; v.exp_err = er; v.exp_cyc = cy;
        vecs.push_back(v);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_rd_en"}, {31'b0, rd_en}, 0);
        chk({tag, "_rd_addr"}, {22'b0, rd_addr}, 0);
        chk({tag, "_out_valid"}, {31'b0, out_valid}, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_index"}, {22'b0, out_index}, 0);
        chk({tag, "_out_last"}, {31'b0, out_last}, 0);
        chk({tag, "_busy"}, {31'b0, busy}, 0);
        chk({tag, "_done"}, {31'b0, done}, 0);
        chk({tag, "_sorted"}, {31'b0, sorted}, 0);
        chk({tag, "_err_len"}, {31'b0, err_len}, 0);
    endtask

    initial begin
        int cyc, n, w;
        logic [31:0] v;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        rst = 1'b1; start = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk1);
        #1;
        check_outputs_zero("reset");
        @(negedge clk1); rst = 1'b0;

        // Directed vectors: expected sorted/err/cycles from the table, beats from the model
        add_vec(4, 10, 20, 25, 50, 0, 1'b1, 1'b0, 15);
        add_vec(4, 10, 25, 50, 20, 0, 1'b0, 1'b0, 15);
        add_vec(2, 7, 3, 0, 0, 2, 1'b0, 1'b0, 0);
        add_vec(3, 32'hFFFFFFFF, 0, 5, 0, 0, 1'b1, 1'b0, 12);
        add_vec(0, 0, 0, 0, 0, 0, 1'b1, 1'b0, 3);
        add_vec(300, 0, 0, 0, 0, 0, 1'b0, 1'b1, 3);
        add_vec(32'h80000001, 0, 0, 0, 0, 0, 1'b0, 1'b1, 3);
        add_vec(3, 5, 5, 5, 0, 1, 1'b1, 1'b0, 0);
        for (int i = 0; i < vecs.size(); i++) begin
            mem[99] = vecs[i].n;
            for (int j = 0; j < 4; j++) mem[100 + j] = vecs[i].e[j];
            do_dump(vecs[i].mode, cyc);
            chk($sformatf("vec%0d_sorted", i), {31'b0, sorted}, {31'b0, vecs[i].exp_sorted});
            chk($sformatf("vec%0d_err", i), {31'b0, err_len}, {31'b0, vecs[i].exp_err});
            check_dump($sformatf("vec%0d", i), vecs[i].exp_cyc, cyc);
        end

        // Max length: 256 ascending elements
        mem[99] = 256;
        for (int j = 0; j < 256; j++) mem[100 + j] = 32'(j * 3 - 100);
        do_dump(0, cyc);
        check_dump("n256", 3 * 256 + 3, cyc);
        chk("n256_last_addr", addr_log.size() > 0 ? addr_log[addr_log.size() - 1] : -1, 355);

        // Randomized dumps
        for (int t = 0; t < 12; t++) begin
            w = $urandom_range(0, 7);
            if (w == 0) n = 257 + $urandom_range(0, 5000);
            else n = $urandom_range(0, 24);
            mem[99] = 32'(n);
            v = $urandom;
            for (int j = 0; j < 24; j++) begin
                if (w[0]) v = v + 32'($urandom_range(0, 3));
                else v = 32'($urandom_range(0, 40)) - 32'd20;
                mem[100 + j] = v;
            end
            do_dump(1, cyc);
            check_dump($sformatf("rand%0d", t), 0, cyc);
        end

        // Reset while beat 2 of 4 is pending
        mem[99] = 4;
        mem[100] = 1; mem[101] = 2; mem[102] = 3; mem[103] = 4;
        clear_logs();
        @(negedge clk1); start = 1'b1; out_ready = 1'b0;
        @(posedge clk1); #1; start = 1'b0;
        w = 0;
        while (!(out_valid && out_index == 2) && w < 200) begin
            out_ready = out_valid && out_index != 2;
            @(posedge clk1); #1; w++;
        end
        chk("rstmid_reached_beat2", {31'b0, out_valid && out_index == 2}, 1);
        @(negedge clk1); rst = 1'b1;
        @(posedge clk1); #1;
        check_outputs_zero("rstmid");
        @(negedge clk1); rst = 1'b0; out_ready = 1'b1;
        @(posedge clk1); #1;
        chk("rstmid_idle_rd_en", {31'b0, rd_en}, 0);
        chk("rstmid_idle_busy", {31'b0, busy}, 0);
        mem[102] = 32'hFFFFFFF0;
        do_dump(0, cyc);
        check_dump("after_rst", 15, cyc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
